stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
Control and sequencing block for the mm:ss stopwatch datapath. It owns the seconds and minutes mod-60 counting chain and advances it on the 1 Hz enable. It also handles run/pause toggling and an adjust mode that steps one selected field at 2 Hz with no carry. Its outputs drive the display formatter: the two field values plus per-field blank strobes for the adjust-mode blink.

Parameters:
MAX_SEC, 59, terminal value of the seconds field; it wraps to 0 after this value.
MAX_MIN, 59, terminal value of the minutes field; it wraps to 0 after this value.
W, 6, width of each field; it must satisfy 2^W > max(MAX_SEC, MAX_MIN).

Ports:
clk  input  1  system clock; all state updates on posedge.
rst  input  1  asynchronous, active-high reset.
tick_1hz  input  1  single-cycle count enable, 1 Hz.
tick_2hz  input  1  single-cycle adjust/blink enable, 2 Hz.
pause_pulse  input  1  single-cycle pulse from an already debounced button; toggles run/pause.
adj  input  1  level; 1 = adjust mode.
sel  input  1  level; adjust target, 0 = minutes, 1 = seconds.
seconds  output  W  current seconds value.
minutes  output  W  current minutes value.
running  output  1  1 when not paused.
blank_sec  output  1  1 = display should blank the seconds digits.
blank_min  output  1  1 = display should blank the minutes digits.

Behaviour:
- Reset (async, rst=1), effective immediately and held while rst=1:
  - seconds=0, minutes=0.
  - paused=0, so running=1.
  - blink phase=0, so blank_sec=0 and blank_min=0.
  - Reset mid-count or mid-adjust simply aborts the operation; there is no pending state.
- Internal state: paused flag (1 bit) and blink phase (1 bit). Mode is combinational:
  - ADJUST when adj=1.
  - RUN when adj=0 and paused=0.
  - PAUSE when adj=0 and paused=1.
- Pause toggle:
  - pause_pulse=1 inverts paused on that edge, in any mode.
  - running is the registered ~paused and updates one cycle after the pulse.
  - A pulse during ADJUST still toggles paused; the new value takes effect when adj drops.
- RUN, on an edge with tick_1hz=1:
  - If seconds<MAX_SEC: seconds+1.
  - If seconds==MAX_SEC: seconds=0. Then minutes+1 if minutes<MAX_MIN, else minutes=0 (59:59 -> 00:00).
  - Both fields update on the same edge.
  - tick_2hz is ignored for counting.
- PAUSE: fields hold; both ticks are ignored.
- Same-edge rule for pause_pulse and tick_1hz: the count decision uses the pre-edge paused value.
  - Running: the tick counts, then the block pauses.
  - Paused: the tick is ignored, then the block resumes.
- ADJUST, on an edge with tick_2hz=1:
  - The selected field increments by 1 and wraps at its MAX to 0. There is no carry into the other field.
  - The unselected field holds.
  - tick_1hz is ignored.
  - Stepping happens regardless of paused.
- Blink:
  - While adj=1, blink phase toggles on each tick_2hz.
  - While adj=0, blink phase is forced to 0 on every edge.
  - blank_min = adj & ~sel & phase; blank_sec = adj & sel & phase. These are registered-phase-derived, glitch-free on a level change of sel.
  - Changing sel mid-adjust does not reset phase; the blink transfers to the new field.
- Leaving ADJUST (adj 1->0):
  - Fields keep their adjusted values.
  - Mode becomes RUN or PAUSE per the paused flag on the next edge.
  - Blanks deassert within one cycle.
- Simultaneous tick_1hz and tick_2hz: only the enable belonging to the current mode acts.
- Latency: every field change is visible on the output the cycle after the enabling edge, with no further pipeline.
- Out-of-range values cannot occur; all increments are bounded by MAX compares (use ==MAX, not overflow).

Test Plan:
- Reset, then 61 tick_1hz pulses in RUN -> seconds=1, minutes=1, running=1, blanks=0. Assert rst asynchronously between clock edges -> outputs 0 before the next edge.
- Preload to 59:58 via adjust, then RUN with 2 tick_1hz -> 59:59 then 00:00 on the same edge for both fields.
- At 00:10 running, pause_pulse coincident with tick_1hz -> 00:11, running=0. Next 5 ticks -> remain 00:11. pause_pulse -> running=1, and the next tick gives 00:12.
- adj=1, sel=1 at seconds=58, 3 tick_2hz -> 59, 0, 1 with minutes unchanged. blank_sec toggles 1,0,1 and blank_min stays 0. Set sel=0 -> blank_min takes the phase and blank_sec=0.
- adj=1 with tick_1hz only (no tick_2hz) for 10 pulses -> fields hold. Drop adj with paused=1 -> fields hold on later tick_1hz and blanks return to 0.
- Paused, then enter adjust and pulse pause_pulse once, then exit adjust -> running=1 and counting resumes on the next tick_1hz.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// mm:ss stopwatch control: mod-60 counting chain, run/pause toggle,
// and a 2 Hz single-field adjust mode with blink strobes.
module stopwatch_ctrl #(
    parameter int unsigned MAX_SEC = 59,
    parameter int unsigned MAX_MIN = 59,
    parameter int unsigned W       = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick_1hz,
    input  logic         tick_2hz,
    input  logic         pause_pulse,
    input  logic         adj,
    input  logic         sel,
    output logic [W-1:0] seconds,
    output logic [W-1:0] minutes,
    output logic         running,
    output logic         blank_sec,
    output logic         blank_min
);

    localparam logic [W-1:0] SEC_LAST = W'(MAX_SEC);
    localparam logic [W-1:0] MIN_LAST = W'(MAX_MIN);
    localparam logic [W-1:0] ONE      = W'(1);

    logic [W-1:0] r_sec;
    logic [W-1:0] r_min;
    logic         r_running;
    logic         r_phase;

    logic [W-1:0] w_sec_nxt;
    logic [W-1:0] w_min_nxt;
    logic         w_running_nxt;
    logic         w_phase_nxt;
    logic [W-1:0] w_sec_inc;
    logic [W-1:0] w_min_inc;
    logic         w_sec_last;

    // Wrapping increments bounded by an equality compare against the terminal value
    always_comb begin
        w_sec_last = (r_sec == SEC_LAST);
        w_sec_inc  = w_sec_last ? '0 : r_sec + ONE;
        w_min_inc  = (r_min == MIN_LAST) ? '0 : r_min + ONE;
    end

    // Next-state: adjust steps one field on tick_2hz; run counts with carry on tick_1hz
    always_comb begin
        w_sec_nxt     = r_sec;
        w_min_nxt     = r_min;
        w_running_nxt = r_running;
        w_phase_nxt   = 1'b0;

        if (adj) begin
            w_phase_nxt = r_phase ^ tick_2hz;
            if (tick_2hz) begin
                if (sel) begin
                    w_sec_nxt = w_sec_inc;
                end else begin
                    w_min_nxt = w_min_inc;
                end
            end
        end else if (r_running && tick_1hz) begin
            w_sec_nxt = w_sec_inc;
            if (w_sec_last) begin
                w_min_nxt = w_min_inc;
            end
        end

        if (pause_pulse) begin
            w_running_nxt = ~r_running;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sec     <= '0;
            r_min     <= '0;
            r_running <= 1'b1;
            r_phase   <= 1'b0;
        end else begin
            r_sec     <= w_sec_nxt;
            r_min     <= w_min_nxt;
            r_running <= w_running_nxt;
            r_phase   <= w_phase_nxt;
        end
    end

    assign seconds   = r_sec;
    assign minutes   = r_min;
    assign running   = r_running;
    // Blink follows the registered phase onto whichever field sel currently picks
    assign blank_sec = adj & sel & r_phase;
    assign blank_min = adj & ~sel & r_phase;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: arithmetic reference model checked
// every cycle, plus directed literal expectations.
module tb_stopwatch_ctrl;

    localparam int unsigned W = 6;
    localparam int SEC_MOD = 60;
    localparam int MIN_MOD = 60;

    logic         clk;
    logic         rst;
    logic         tick_1hz;
    logic         tick_2hz;
    logic         pause_pulse;
    logic         adj;
    logic         sel;
    logic [W-1:0] seconds;
    logic [W-1:0] minutes;
    logic         running;
    logic         blank_sec;
    logic         blank_min;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    int m_sec;
    int m_min;
    bit m_paused;
    bit m_phase;

    stopwatch_ctrl #(.MAX_SEC(59), .MAX_MIN(59), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_1hz   (tick_1hz),
        .tick_2hz   (tick_2hz),
        .pause_pulse(pause_pulse),
        .adj        (adj),
        .sel        (sel),
        .seconds    (seconds),
        .minutes    (minutes),
        .running    (running),
        .blank_sec  (blank_sec),
        .blank_min  (blank_min)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: time as a single count of seconds in a 60-minute hour
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_sec    <= 0;
            m_min    <= 0;
            m_paused <= 1'b0;
            m_phase  <= 1'b0;
        end else begin
            if (adj) begin
                if (tick_2hz) begin
                    m_phase <= !m_phase;
                    if (sel) m_sec <= (m_sec + 1) % SEC_MOD;
                    else     m_min <= (m_min + 1) % MIN_MOD;
                end
            end else begin
                m_phase <= 1'b0;
                if (!m_paused && tick_1hz) begin
                    m_sec <= ((m_min * SEC_MOD + m_sec + 1) % (SEC_MOD * MIN_MOD)) % SEC_MOD;
                    m_min <= ((m_min * SEC_MOD + m_sec + 1) % (SEC_MOD * MIN_MOD)) / SEC_MOD;
                end
            end
            if (pause_pulse) m_paused <= !m_paused;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_seconds", int'(seconds), m_sec);
            chk("model_minutes", int'(minutes), m_min);
            chk("model_running", int'(running), int'(!m_paused));
            chk("model_blank_sec", int'(blank_sec), int'(adj && sel && m_phase));
            chk("model_blank_min", int'(blank_min), int'(adj && !sel && m_phase));
        end
    end

    task automatic lit(input string name, input int s, input int m, input int r,
                       input int bs, input int bm);
        chk({name, "_sec"}, int'(seconds), s);
        chk({name, "_min"}, int'(minutes), m);
        chk({name, "_run"}, int'(running), r);
        chk({name, "_bsec"}, int'(blank_sec), bs);
        chk({name, "_bmin"}, int'(blank_min), bm);
    endtask

    task automatic step(input logic t1, input logic t2, input logic pp);
        tick_1hz    = t1;
        tick_2hz    = t2;
        pause_pulse = pp;
        @(posedge clk);
        #1;
        tick_1hz    = 1'b0;
        tick_2hz    = 1'b0;
        pause_pulse = 1'b0;
    endtask

    initial begin
        rst = 1'b0; tick_1hz = 1'b0; tick_2hz = 1'b0; pause_pulse = 1'b0;
        adj = 1'b0; sel = 1'b0;
        #1 rst = 1'b1;
        #1 chk_en = 1;
        lit("reset", 0, 0, 1, 0, 0);
        @(posedge clk); #1 rst = 1'b0;

        repeat (61) begin
            step(1'b1, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0);
        end
        lit("count61", 1, 1, 1, 0, 0);

        #2 rst = 1'b1;
        #1 lit("async_rst", 0, 0, 1, 0, 0);
        @(posedge clk); #1 rst = 1'b0;

        // Preload 59:58 through adjust
        adj = 1'b1; sel = 1'b0;
        repeat (59) step(1'b0, 1'b1, 1'b0);
        sel = 1'b1;
        repeat (58) step(1'b0, 1'b1, 1'b0);
        lit("preload", 58, 59, 1, 1, 0);
        adj = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        lit("pre_wrap", 59, 59, 1, 0, 0);
        step(1'b1, 1'b0, 1'b0);
        lit("full_wrap", 0, 0, 1, 0, 0);

        repeat (10) step(1'b1, 1'b0, 1'b0);
        lit("at_10", 10, 0, 1, 0, 0);
        step(1'b1, 1'b0, 1'b1);
        lit("tick_then_pause", 11, 0, 0, 0, 0);
        repeat (5) step(1'b1, 1'b0, 1'b0);
        lit("paused_hold", 11, 0, 0, 0, 0);
        step(1'b0, 1'b0, 1'b1);
        lit("resume", 11, 0, 1, 0, 0);
        step(1'b1, 1'b0, 1'b0);
        lit("resume_tick", 12, 0, 1, 0, 0);

        adj = 1'b1; sel = 1'b1;
        repeat (46) step(1'b0, 1'b1, 1'b0);
        lit("adj_58", 58, 0, 1, 0, 0);
        step(1'b0, 1'b1, 1'b0);
        lit("adj_59", 59, 0, 1, 1, 0);
        step(1'b0, 1'b1, 1'b0);
        lit("adj_wrap0", 0, 0, 1, 0, 0);
        step(1'b0, 1'b1, 1'b0);
        lit("adj_1", 1, 0, 1, 1, 0);
        sel = 1'b0;
        #1 lit("sel_swap", 1, 0, 1, 0, 1);

        repeat (10) step(1'b1, 1'b0, 1'b0);
        lit("adj_ignore_1hz", 1, 0, 1, 0, 1);
        step(1'b0, 1'b0, 1'b1);
        lit("adj_pause", 1, 0, 0, 0, 1);
        adj = 1'b0;
        repeat (3) step(1'b1, 1'b0, 1'b0);
        lit("exit_paused", 1, 0, 0, 0, 0);

        adj = 1'b1;
        step(1'b0, 1'b0, 1'b1);
        lit("adj_resume", 1, 0, 1, 0, 0);
        adj = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        lit("exit_run", 2, 0, 1, 0, 0);

        step(1'b1, 1'b1, 1'b0);
        lit("both_run", 3, 0, 1, 0, 0);
        adj = 1'b1; sel = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        lit("both_adj", 4, 0, 1, 1, 0);
        adj = 1'b0;
        step(1'b0, 1'b0, 1'b0);

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
